block_mem_2port: RTL

BLOCK_MEM_2PORT -- requirements
Module: block_mem_2port

---
 rtl/block_mem_pkg.sv | 45 ++++
 rtl/rr_arbiter2.sv | 43 ++++
 rtl/block_mem_2port.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/block_mem_pkg.sv
// block_mem_pkg
//   Shared definitions for block_mem_2port: the controller state encoding,
//   default parameter values, the block-base address helper and the
//   power-up demo image.
package block_mem_pkg;

  localparam int DEF_WORD_W    = 32;
  localparam int DEF_WPB       = 4;
  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_INDEX_W   = 16;
  localparam int DEF_LATENCY   = 4;
  localparam int DEF_INIT_DEMO = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Keeps the low index_w address bits (upper bits wrap away) and clears the
  // low wpb_lg bits so the result points at the first word of the block.
  function automatic logic [63:0] block_base(input logic [63:0] addr,
                                             input int          index_w,
                                             input int          wpb_lg);
    logic [63:0] keep;
    logic [63:0] low;
    keep = (index_w >= 64) ? '1 : ((64'd1 << index_w) - 64'd1);
    low  = (64'd1 << wpb_lg) - 64'd1;
    return addr & keep & ~low;
  endfunction

  // Contents of the demo image: words 0..5 = 1,1,1,10,8,5, all others 0.
  function automatic logic [31:0] demo_word(input logic [63:0] idx);
    logic [31:0] w;
    case (idx)
      64'd0, 64'd1, 64'd2: w = 32'd1;
      64'd3:               w = 32'd10;
      64'd4:               w = 32'd8;
      64'd5:               w = 32'd5;
      default:             w = 32'd0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
//   Two-requester round-robin arbiter. The pointer names the port that wins
//   when both request; after every accepted grant the other port gets
//   priority. A lone requester always wins.
// Ports
//   clk, rst  : clock, synchronous active-high reset (pointer -> port 0)
//   i_req     : request vector, bit N = port N
//   i_take    : the current grant was accepted this cycle
//   o_gnt     : one-hot grant (zero when nobody requests)
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output logic [1:0] o_gnt
);

  logic r_ptr;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = r_ptr ? 2'b10 : 2'b01;
      default: o_gnt = 2'b00;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (i_take) begin
      // Port 0 just won -> port 1 has priority next, and vice versa.
      r_ptr <= o_gnt[0];
    end
  end

endmodule

// File: rtl/block_mem_2port.sv
// block_mem_2port
//   Two-port block memory controller. Requests from two ports share one
//   word array; one request is serviced at a time (IDLE -> ACCESS -> RESP),
//   arbitrated round-robin. Each request reads or writes a whole block of
//   WPB words aligned to a WPB boundary.
// Ports (N = 0,1)
//   clk, rst       : clock, synchronous active-high reset
//   pN_req_valid   : request present
//   pN_req_ready   : request accepted this cycle if valid
//   pN_we          : 1 = block write, 0 = block read
//   pN_addr        : word address anywhere inside the target block
//   pN_wdata       : write block, word i at [i*WORD_W +: WORD_W]
//   pN_resp_valid  : one-cycle completion pulse
//   pN_rdata       : read block (write echo), held until the next response
module block_mem_2port
  import block_mem_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int WPB       = DEF_WPB,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int INDEX_W   = DEF_INDEX_W,
  parameter int LATENCY   = DEF_LATENCY,
  parameter int INIT_DEMO = DEF_INIT_DEMO
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic                  p0_we,
  input  logic [ADDR_W-1:0]     p0_addr,
  input  logic [WORD_W*WPB-1:0] p0_wdata,
  output logic                  p0_resp_valid,
  output logic [WORD_W*WPB-1:0] p0_rdata,
  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic                  p1_we,
  input  logic [ADDR_W-1:0]     p1_addr,
  input  logic [WORD_W*WPB-1:0] p1_wdata,
  output logic                  p1_resp_valid,
  output logic [WORD_W*WPB-1:0] p1_rdata
);

  localparam int BLK_W  = WORD_W * WPB;
  localparam int WPB_LG = $clog2(WPB);
  localparam int DEPTH  = 1 << INDEX_W;
  localparam int CNT_W  = $clog2(LATENCY + 1);
  // ACCESS lasts LATENCY-1 cycles: load LATENCY-2, leave when it reaches 0.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  // The array stores data XOR the power-up image. Storage that powers up as
  // zero therefore reads back the demo contents without any init logic.
  function automatic logic [WORD_W-1:0] init_word(input logic [INDEX_W-1:0] idx);
    return (INIT_DEMO != 0) ? WORD_W'(demo_word(64'(idx))) : '0;
  endfunction

  logic [WORD_W-1:0] r_mem [DEPTH];

  state_e             r_state;
  state_e             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_port;
  logic               r_we;
  logic [INDEX_W-1:0] r_base;
  logic [BLK_W-1:0]   r_wdata;
  logic [1:0]         r_resp_valid;
  logic [BLK_W-1:0]   r_rdata0;
  logic [BLK_W-1:0]   r_rdata1;

  logic [1:0]         w_gnt;
  logic               w_idle;
  logic               w_hs0;
  logic               w_hs1;
  logic               w_accept;
  logic               w_commit;
  logic               w_in_port;
  logic               w_in_we;
  logic [ADDR_W-1:0]  w_in_addr;
  logic [INDEX_W-1:0] w_in_base;
  logic [BLK_W-1:0]   w_in_wdata;
  logic               w_acc_port;
  logic               w_acc_we;
  logic [INDEX_W-1:0] w_acc_base;
  logic [BLK_W-1:0]   w_acc_wdata;
  logic [INDEX_W-1:0] w_word_idx [WPB];
  logic [WORD_W-1:0]  w_init     [WPB];
  logic [BLK_W-1:0]   w_rd_block;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .i_req  ({p1_req_valid, p0_req_valid}),
    .i_take (w_accept),
    .o_gnt  (w_gnt)
  );

  // Ready is combinational; gating with rst keeps it low on reset edges.
  assign w_idle       = (r_state == IDLE) && !rst;
  assign p0_req_ready = w_idle && w_gnt[0];
  assign p1_req_ready = w_idle && w_gnt[1];
  assign w_hs0        = p0_req_valid && p0_req_ready;
  assign w_hs1        = p1_req_valid && p1_req_ready;
  assign w_accept     = w_hs0 || w_hs1;

  assign w_in_port  = w_hs1;
  assign w_in_we    = w_in_port ? p1_we    : p0_we;
  assign w_in_addr  = w_in_port ? p1_addr  : p0_addr;
  assign w_in_wdata = w_in_port ? p1_wdata : p0_wdata;
  assign w_in_base  = INDEX_W'(block_base(64'(w_in_addr), INDEX_W, WPB_LG));

  // The access runs on the edge entering RESP. From IDLE (LATENCY = 1) the
  // request has not been captured yet, so the live inputs are used.
  assign w_acc_port  = (r_state == IDLE) ? w_in_port  : r_port;
  assign w_acc_we    = (r_state == IDLE) ? w_in_we    : r_we;
  assign w_acc_base  = (r_state == IDLE) ? w_in_base  : r_base;
  assign w_acc_wdata = (r_state == IDLE) ? w_in_wdata : r_wdata;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = (LATENCY == 1) ? RESP : ACCESS;
      ACCESS:  if (r_cnt == '0) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_commit = !rst && (w_next == RESP);

  always_comb begin
    w_rd_block = '0;
    for (int i = 0; i < WPB; i++) begin
      w_word_idx[i] = w_acc_base | INDEX_W'(i);
      w_init[i]     = init_word(w_word_idx[i]);
      w_rd_block[i*WORD_W +: WORD_W] = r_mem[w_word_idx[i]] ^ w_init[i];
    end
  end

  // NOTE: the array has no reset branch; memories keep their contents
  // across reset and a reset loop would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (w_commit && w_acc_we) begin
      for (int i = 0; i < WPB; i++) begin
        r_mem[w_word_idx[i]] <= w_acc_wdata[i*WORD_W +: WORD_W] ^ w_init[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_port       <= 1'b0;
      r_we         <= 1'b0;
      r_base       <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 2'b00;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      r_state      <= w_next;
      r_resp_valid <= 2'b00;

      if ((r_state == IDLE) && w_accept) begin
        r_cnt   <= CNT_LOAD;
        r_port  <= w_in_port;
        r_we    <= w_in_we;
        r_base  <= w_in_base;
        r_wdata <= w_in_wdata;
      end else if ((r_state == ACCESS) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end

      // Only the serviced port's response registers change.
      if (w_commit) begin
        if (w_acc_port) begin
          r_resp_valid[1] <= 1'b1;
          r_rdata1        <= w_acc_we ? w_acc_wdata : w_rd_block;
        end else begin
          r_resp_valid[0] <= 1'b1;
          r_rdata0        <= w_acc_we ? w_acc_wdata : w_rd_block;
        end
      end
    end
  end

  assign p0_resp_valid = r_resp_valid[0];
  assign p1_resp_valid = r_resp_valid[1];
  assign p0_rdata      = r_rdata0;
  assign p1_rdata      = r_rdata1;

endmodule
